// File: rtl/uart_pkg.sv
// Shared UART encodings and helpers, used by both the Tx and Rx sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP     = 3'd5,
    ST_SYNC_BRK = 3'd6,
    ST_BREAK    = 3'd7
  } uart_state_t;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  // Bit periods in one frame: start + data + optional parity + 1 or 2 stop.
  function automatic int frame_ticks(input int data_w, input logic par_en, input logic stop2);
    return 2 + data_w + (par_en ? 1 : 0) + (stop2 ? 1 : 0);
  endfunction

  // Payload is zero-extended by the caller; extra zeros do not change the XOR.
  function automatic logic par_bit(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// One-entry holding buffer in front of the Tx serializer; captures payload and frame config together.
module uart_tx_hold_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] TX_DATA,
  input  logic         TX_VALID,
  output logic         TX_READY,
  input  logic         PAR_EN,
  input  logic         PAR_ODD,
  input  logic         STOP2,
  input  logic         TAKE,
  output logic         HOLD_FULL,
  output logic [W-1:0] HOLD_DATA,
  output logic         HOLD_PAR_EN,
  output logic         HOLD_PAR_ODD,
  output logic         HOLD_STOP2
);

  // Handshake: a payload moves on any rising CLK where TX_VALID && TX_READY;
  // TX_READY depends only on local state, never on TX_VALID.
  logic hold_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_full    <= 1'b0;
      HOLD_DATA    <= '0;
      HOLD_PAR_EN  <= 1'b0;
      HOLD_PAR_ODD <= 1'b0;
      HOLD_STOP2   <= 1'b0;
    end else if (TX_VALID && !hold_full) begin
      hold_full    <= 1'b1;
      HOLD_DATA    <= TX_DATA;
      HOLD_PAR_EN  <= PAR_EN;
      HOLD_PAR_ODD <= PAR_ODD;
      HOLD_STOP2   <= STOP2;
    end else if (TAKE) begin
      hold_full <= 1'b0;
    end
  end

  assign TX_READY  = ~hold_full;
  assign HOLD_FULL = hold_full;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit engine: holding buffer, frame FSM, serializer, parity and stop bits.
// Define UART_TX_BREAK_EN to add the BRK_REQ input and the line-break states.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BRK_LEN = 13
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic              PAR_EN,
  input  logic              PAR_ODD,
  input  logic              STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic              BRK_REQ,
`endif
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [2:0]        STATE_DBG
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || BRK_LEN < 1) begin : g_param_check
    $error("uart_tx_frame_ctrl: illegal DATA_W or BRK_LEN");
  end

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              hold_par_en;
  logic              hold_par_odd;
  logic              hold_stop2;
  logic              take;

  uart_tx_hold_reg #(.W(DATA_W)) u_hold (
    .CLK          (CLK),
    .RST          (RST),
    .TX_DATA      (TX_DATA),
    .TX_VALID     (TX_VALID),
    .TX_READY     (TX_READY),
    .PAR_EN       (PAR_EN),
    .PAR_ODD      (PAR_ODD),
    .STOP2        (STOP2),
    .TAKE         (take),
    .HOLD_FULL    (hold_full),
    .HOLD_DATA    (hold_data),
    .HOLD_PAR_EN  (hold_par_en),
    .HOLD_PAR_ODD (hold_par_odd),
    .HOLD_STOP2   (hold_stop2)
  );

  uart_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              par_en_q;
  logic              stop2_q;
  logic              par_q;
  logic              stop_cnt;
  logic              tx_q;
  logic              done_q;
  logic              stop_last;

`ifdef UART_TX_BREAK_EN
  localparam int BW = $clog2(BRK_LEN + 1);
  localparam logic [BW-1:0] BRK_LOW_LAST = BW'(BRK_LEN - 1);
  localparam logic [BW-1:0] BRK_END      = BW'(BRK_LEN);
  logic [BW-1:0] brk_cnt;
`endif

  // stop_cnt marks that the first of two stop periods has already elapsed.
  assign stop_last = ~stop2_q | stop_cnt;

  always_comb begin
    take = 1'b0;
    case (state)
`ifdef UART_TX_BREAK_EN
      ST_IDLE: take = hold_full & ~BRK_REQ;
`else
      ST_IDLE: take = hold_full;
`endif
      ST_STOP: take = TICK & stop_last & hold_full;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // Frame config and parity are frozen here so mid-frame input changes are ignored.
      if (take) begin
        shreg    <= hold_data;
        par_en_q <= hold_par_en;
        stop2_q  <= hold_stop2;
        par_q    <= par_bit(DATA_W_MAX'(hold_data), hold_par_odd);
      end
      case (state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (BRK_REQ) state <= ST_SYNC_BRK;
          else
`endif
          if (hold_full) state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (TICK) begin
            tx_q  <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (TICK) begin
            tx_q    <= shreg[0];
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (TICK) begin
            if (bit_cnt == BIT_LAST) begin
              stop_cnt <= 1'b0;
              if (par_en_q) begin
                tx_q  <= par_q;
                state <= ST_PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (TICK) begin
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (TICK) begin
            if (stop_last) begin
              done_q <= 1'b1;
              // A waiting payload starts immediately, so frames run with no idle gap.
              if (hold_full) begin
                tx_q  <= 1'b0;
                state <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_SYNC_BRK: begin
          if (TICK) begin
            tx_q    <= 1'b0;
            brk_cnt <= '0;
            state   <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          // BRK_LEN low periods, then one high stop period before returning to idle.
          if (TICK) begin
            if (brk_cnt == BRK_END) begin
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              if (brk_cnt == BRK_LOW_LAST) tx_q <= 1'b1;
              brk_cnt <= brk_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign TX_OUT     = tx_q;
  assign FRAME_DONE = done_q;
  assign BUSY       = (state != ST_IDLE) | hold_full;
  assign STATE_DBG  = state;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: an 8-bit and a 5-bit instance share CLK and TICK; a line monitor rebuilds frames.
`timescale 1ns/1ps
module tb_uart_tx_frame_ctrl;
  import uart_pkg::*;

  localparam int WA = 8;
  localparam int WB = 5;
  localparam int EW = 22;  // {len[5:0], line bits[15:0]}

  // clock/reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TICK = 1'b0;
  int   tick_div = 0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    tick_div = (tick_div == 3) ? 0 : tick_div + 1;
    TICK = (tick_div == 0);
  end

  logic [WA-1:0] a_data = '0;
  logic a_valid = 1'b0, a_par_en = 1'b0, a_par_odd = 1'b0, a_stop2 = 1'b0;
  logic a_ready, a_tx, a_busy, a_done;
  logic [2:0] a_state;
  logic [WB-1:0] b_data = '0;
  logic b_valid = 1'b0, b_par_en = 1'b0, b_par_odd = 1'b0, b_stop2 = 1'b0;
  logic b_ready, b_tx, b_busy, b_done;
  logic [2:0] b_state;
`ifdef UART_TX_BREAK_EN
  logic a_brk = 1'b0;
  logic b_brk = 1'b0;
`endif

  uart_tx_frame_ctrl #(.DATA_W(WA)) dut_a (
    .CLK(CLK), .RST(RST), .TICK(TICK), .TX_DATA(a_data), .TX_VALID(a_valid), .TX_READY(a_ready),
    .PAR_EN(a_par_en), .PAR_ODD(a_par_odd), .STOP2(a_stop2),
`ifdef UART_TX_BREAK_EN
    .BRK_REQ(a_brk),
`endif
    .TX_OUT(a_tx), .BUSY(a_busy), .FRAME_DONE(a_done), .STATE_DBG(a_state)
  );

  uart_tx_frame_ctrl #(.DATA_W(WB)) dut_b (
    .CLK(CLK), .RST(RST), .TICK(TICK), .TX_DATA(b_data), .TX_VALID(b_valid), .TX_READY(b_ready),
    .PAR_EN(b_par_en), .PAR_ODD(b_par_odd), .STOP2(b_stop2),
`ifdef UART_TX_BREAK_EN
    .BRK_REQ(b_brk),
`endif
    .TX_OUT(b_tx), .BUSY(b_busy), .FRAME_DONE(b_done), .STATE_DBG(b_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk_frame(input logic [8:0] d, input int w,
                                             input logic pe, input logic po, input logic s2);
    logic [15:0] b;
    int n;
    int ones;
    b = '0;
    n = 1;
    ones = 0;
    for (int i = 0; i < w; i++) begin
      b[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pe) begin
      b[n] = po ? ~ones[0] : ones[0];
      n++;
    end
    b[n] = 1'b1;
    n++;
    if (s2) begin
      b[n] = 1'b1;
      n++;
    end
    return {6'(n), b};
  endfunction

  // line monitor
  int rem[2];
  int pos[2];
  logic pend[2];
  logic [15:0] cap[2];
  logic [EW-1:0] cur[2];
  logic [15:0] last_cap[2];
  int last_len[2];
  int done_cnt[2];
  int tick_cnt = 0;
  int start_a[$];
  int end_a[$];
  logic tick_seen;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; pos[k] = 0; pend[k] = 1'b0; cap[k] = '0; cur[k] = '0;
      last_cap[k] = '0; last_len[k] = 0; done_cnt[k] = 0;
    end
  end

  task automatic monitor_step(input int k, input logic tx, input logic fd, input logic tk);
    logic ended;
    ended = 1'b0;
    if (fd) done_cnt[k]++;
    if (tk && pend[k]) begin
      check_val("done_pulse", fd, 1);
      pend[k] = 1'b0;
      ended = 1'b1;
      if (k == 0) end_a.push_back(tick_cnt);
    end
    if (fd && !ended) check_val("stray_done", fd, 0);
    if (tk) begin
      if (rem[k] == 0) begin
        if (tx == 1'b0) begin
          if ((k == 0 && exp_qa.size() == 0) || (k == 1 && exp_qb.size() == 0)) begin
            check_val("unexp_frame", tx, 1);
          end else begin
            if (k == 0) cur[k] = exp_qa.pop_front();
            else cur[k] = exp_qb.pop_front();
            cap[k] = '0;
            cap[k][0] = tx;
            pos[k] = 1;
            rem[k] = int'(cur[k][21:16]) - 1;
            if (k == 0) start_a.push_back(tick_cnt);
          end
        end
      end else begin
        cap[k][pos[k]] = tx;
        pos[k]++;
        rem[k]--;
        if (rem[k] == 0) begin
          check_val("frame_bits", cap[k], cur[k][15:0]);
          last_cap[k] = cap[k];
          last_len[k] = pos[k];
          pend[k] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge CLK) begin
    tick_seen = TICK;
    #1;
    if (tick_seen) tick_cnt++;
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] = 0;
        pend[k] = 1'b0;
      end
    end else begin
      monitor_step(0, a_tx, a_done, tick_seen);
      monitor_step(1, b_tx, b_done, tick_seen);
    end
  end

  // driver tasks
  task automatic send_frame(input int k, input logic [8:0] d, input logic pe, input logic po, input logic s2);
    int n;
    logic rdy;
    n = 0;
    @(negedge CLK);
    if (k == 0) begin
      a_data = d[WA-1:0]; a_par_en = pe; a_par_odd = po; a_stop2 = s2; a_valid = 1'b1;
    end else begin
      b_data = d[WB-1:0]; b_par_en = pe; b_par_odd = po; b_stop2 = s2; b_valid = 1'b1;
    end
    rdy = (k == 0) ? a_ready : b_ready;
    while (!rdy && n < 2000) begin
      @(negedge CLK);
      n++;
      rdy = (k == 0) ? a_ready : b_ready;
    end
    if (!rdy) begin
      check_val("ready_timeout", rdy, 1);
    end else begin
      @(posedge CLK);
      if (k == 0) exp_qa.push_back(mk_frame(d, WA, pe, po, s2));
      else exp_qb.push_back(mk_frame(d, WB, pe, po, s2));
      #1;
      check_val("ready_low_after_accept", (k == 0) ? a_ready : b_ready, 0);
    end
  endtask

  task automatic release_valid(input int k);
    @(negedge CLK);
    if (k == 0) a_valid = 1'b0;
    else b_valid = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int n;
    logic active;
    n = 0;
    active = 1'b1;
    while (active && n < 3000) begin
      @(negedge CLK);
      n++;
      if (k == 0) active = (exp_qa.size() != 0) || (rem[0] != 0) || pend[0] || a_busy;
      else active = (exp_qb.size() != 0) || (rem[1] != 0) || pend[1] || b_busy;
    end
    check_val("drain_busy", (k == 0) ? a_busy : b_busy, 0);
    check_val("drain_queue", (k == 0) ? exp_qa.size() : exp_qb.size(), 0);
  endtask

  task automatic wait_mid_frame(input int k, input int min_pos);
    int n;
    n = 0;
    while (!(rem[k] != 0 && pos[k] >= min_pos) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check_val("mid_frame_reached", (rem[k] != 0) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, ns, ne;
    repeat (3) @(negedge CLK);
    check_val("rst_tx", a_tx, 1);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_ready", a_ready, 1);
    check_val("rst_done", a_done, 0);
    check_val("rst_state", a_state, ST_IDLE);
    check_val("rst_b_tx", b_tx, 1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // T2: 0xA5, 8N1
    d0 = done_cnt[0];
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    release_valid(0);
    check_val("t2_busy", a_busy, 1);
    wait_drain(0);
    check_val("t2_line", last_cap[0][9:0], 10'b1101001010);
    check_val("t2_len", last_len[0], 10);
    check_val("t2_one_done", done_cnt[0] - d0, 1);

    // T3: 0x35, odd parity, two stop bits
    send_frame(0, 9'h035, 1'b1, 1'b1, 1'b1);
    release_valid(0);
    wait_drain(0);
    check_val("t3_line", last_cap[0][11:0], 12'b111001101010);
    check_val("t3_len", last_len[0], frame_ticks(WA, 1'b1, 1'b1));

    // T4: back-to-back with TX_VALID held
    ns = start_a.size();
    ne = end_a.size();
    send_frame(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h081, 1'b1, 1'b0, 1'b0);
    release_valid(0);
    wait_drain(0);
    if (start_a.size() >= ns + 2 && end_a.size() >= ne + 1)
      check_val("t4_zero_gap", start_a[ns + 1], end_a[ne]);
    else
      check_val("t4_frame_count", start_a.size() - ns, 2);

    // T5: DATA_W=5, 0x1F, even parity; PAR_ODD toggled mid-frame
    send_frame(1, 9'h01F, 1'b1, 1'b0, 1'b0);
    release_valid(1);
    wait_mid_frame(1, 3);
    @(negedge CLK);
    b_par_odd = 1'b1;
    wait_drain(1);
    check_val("t5_line", last_cap[1][7:0], 8'b11111110);
    check_val("t5_len", last_len[1], 8);

    // random traffic on both widths
    for (int i = 0; i < 8; i++) begin
      send_frame(0, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) release_valid(0);
    end
    release_valid(0);
    wait_drain(0);
    for (int i = 0; i < 4; i++) begin
      send_frame(1, 9'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    release_valid(1);
    wait_drain(1);

    // T1: asynchronous reset mid-DATA with the holding buffer full
    d0 = done_cnt[0];
    send_frame(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    wait_mid_frame(0, 4);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    a_valid = 1'b0;
    #1;
    check_val("t1_tx", a_tx, 1);
    check_val("t1_busy", a_busy, 0);
    check_val("t1_ready", a_ready, 1);
    check_val("t1_done", a_done, 0);
    check_val("t1_state", a_state, ST_IDLE);
    @(negedge CLK);
    exp_qa.delete();
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    check_val("t1_no_done", done_cnt[0] - d0, 0);
    check_val("t1_idle_tx", a_tx, 1);

`ifdef UART_TX_BREAK_EN
    // T6: break requested in IDLE while the buffer is full
    @(negedge CLK);
    a_data = 8'h66; a_par_en = 1'b0; a_par_odd = 1'b0; a_stop2 = 1'b0; a_valid = 1'b1;
    @(posedge CLK);
    #1;
    exp_qa.push_back({6'd14, 16'h2000});
    exp_qa.push_back(mk_frame(9'h066, WA, 1'b0, 1'b0, 1'b0));
    @(negedge CLK);
    a_valid = 1'b0;
    a_brk = 1'b1;
    @(negedge CLK);
    a_brk = 1'b0;
    wait_mid_frame(0, 5);
    check_val("t6_hold_kept", a_ready, 0);
    check_val("t6_busy", a_busy, 1);
    wait_drain(0);
    check_val("t6_data_after_brk", last_cap[0][9:0], 10'b1011001100);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
